// File: rtl/simd_sequencer.sv
// simd_sequencer: steps one instruction across a wave, one lane group per pass.
// Per lane group: REQUEST -> (WAIT for memory) -> EXECUTE -> UPDATE; after the last group, DONE.
// Optional feature macro: SIMD_WAIT_TIMEOUT_EN. When defined, WAIT gives up after TIMEOUT
// cycles without mem_ready and sets timeout_err. When undefined, WAIT holds indefinitely.
module simd_sequencer #(
    parameter int WAVE_SIZE  = 32,
    parameter int LANE_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic signed [31:0]                         wave_id_in,
    input  logic                                       reg_write_in,
    input  logic                                       mem_op_in,
    input  logic                                       mem_ready,
    output logic [2:0]                                 simd_state,
    output logic [$clog2(WAVE_SIZE/LANE_WIDTH):0]      curr_wave_cycle,
    output logic signed [31:0]                         wave_id,
    output logic                                       enable,
    output logic                                       REG_WRITE,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       timeout_err
);

    localparam int NUM_CYCLES = WAVE_SIZE / LANE_WIDTH;
    localparam int CW         = $clog2(NUM_CYCLES) + 1;
    localparam logic [CW-1:0] LastCycle = CW'(NUM_CYCLES - 1);

    // Reject configurations that cannot sequence anything.
    if (NUM_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("simd_sequencer: NUM_CYCLES and TIMEOUT must both be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRequest = 3'd1,
        StWait    = 3'd2,
        StExecute = 3'd3,
        StUpdate  = 3'd4,
        StDone    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cwc_q, cwc_d;
    logic signed [31:0] wave_id_q;
    logic               reg_write_q;
    logic               mem_op_q;
    logic               accept;

`ifdef SIMD_WAIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;
    logic          timeout_err_q;
`endif

    // Next-state logic for the sequencing FSM and the lane-group index.
    always_comb begin
        state_d = state_q;
        cwc_d   = cwc_q;
        accept  = 1'b0;
`ifdef SIMD_WAIT_TIMEOUT_EN
        tmo_hit = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    cwc_d   = '0;
                    state_d = StRequest;
                end
            end
            StRequest: state_d = mem_op_q ? StWait : StExecute;
            StWait: begin
                if (mem_ready) begin
                    state_d = StExecute;
                end
`ifdef SIMD_WAIT_TIMEOUT_EN
                else if (tmo_cnt_q == TmoLast) begin
                    // Abandon the rest of the wave.
                    state_d = StDone;
                    tmo_hit = 1'b1;
                end
`endif
            end
            StExecute: state_d = StUpdate;
            StUpdate: begin
                if (cwc_q == LastCycle) begin
                    state_d = StDone;
                end else begin
                    cwc_d   = cwc_q + 1'b1;
                    state_d = StRequest;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, lane-group index and per-instruction latches (captured only on accept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cwc_q       <= '0;
            wave_id_q   <= '0;
            reg_write_q <= 1'b0;
            mem_op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cwc_q   <= cwc_d;
            if (accept) begin
                wave_id_q   <= wave_id_in;
                reg_write_q <= reg_write_in;
                mem_op_q    <= mem_op_in;
            end
        end
    end

`ifdef SIMD_WAIT_TIMEOUT_EN
    // Count consecutive WAIT cycles without mem_ready; cleared whenever WAIT is left.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == StWait && !mem_ready && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout counter and sticky error flag (cleared by the next accept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (accept) begin
                timeout_err_q <= 1'b0;
            end else if (tmo_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign simd_state      = state_q;
    assign curr_wave_cycle = cwc_q;
    assign wave_id         = wave_id_q;
    assign busy            = (state_q != StIdle);
    assign enable          = busy;
    assign done            = (state_q == StDone);
    assign REG_WRITE       = reg_write_q && (state_q == StUpdate);

endmodule

// File: tb/tb_simd_sequencer.sv
// Scoreboard bench for simd_sequencer: stimulus queues the expected per-cycle trace of each
// instruction; a negedge monitor pops one entry for every cycle the DUT reports busy.
module tb_simd_sequencer;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [31:0] wave_id_in;
    logic               reg_write_in;
    logic               mem_op_in;
    logic               mem_ready;
    logic [2:0]         simd_state;
    logic [1:0]         curr_wave_cycle;
    logic signed [31:0] wave_id;
    logic               enable;
    logic               reg_write;
    logic               busy;
    logic               done;
    logic               timeout_err;

    simd_sequencer #(
        .WAVE_SIZE (32),
        .LANE_WIDTH(16),
        .TIMEOUT   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .wave_id_in     (wave_id_in),
        .reg_write_in   (reg_write_in),
        .mem_op_in      (mem_op_in),
        .mem_ready      (mem_ready),
        .simd_state     (simd_state),
        .curr_wave_cycle(curr_wave_cycle),
        .wave_id        (wave_id),
        .enable         (enable),
        .REG_WRITE      (reg_write),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  cwc;
        logic        rw;
        logic        dn;
        logic [31:0] wid;
        logic        te;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [1:0] cwc, input logic rw,
                        input logic dn, input logic [31:0] wid, input logic te);
        exp_t e;
        e.st  = st;
        e.cwc = cwc;
        e.rw  = rw;
        e.dn  = dn;
        e.wid = wid;
        e.te  = te;
        exp_q.push_back(e);
    endtask

    // No-memory instruction: states 1,3,4,1,3,4,5; strobe only in the UPDATEs.
    task automatic push_plain(input logic [31:0] w, input logic rw);
        push(3'd1, 2'd0, 1'b0, 1'b0, w, 1'b0);
        push(3'd3, 2'd0, 1'b0, 1'b0, w, 1'b0);
        push(3'd4, 2'd0, rw,   1'b0, w, 1'b0);
        push(3'd1, 2'd1, 1'b0, 1'b0, w, 1'b0);
        push(3'd3, 2'd1, 1'b0, 1'b0, w, 1'b0);
        push(3'd4, 2'd1, rw,   1'b0, w, 1'b0);
        push(3'd5, 2'd1, 1'b0, 1'b1, w, 1'b0);
    endtask

    // Memory instruction with n0 / n1 WAIT cycles in lane groups 0 / 1.
    task automatic push_mem(input logic [31:0] w, input logic rw, input int n0, input int n1);
        push(3'd1, 2'd0, 1'b0, 1'b0, w, 1'b0);
        for (int i = 0; i < n0; i++) push(3'd2, 2'd0, 1'b0, 1'b0, w, 1'b0);
        push(3'd3, 2'd0, 1'b0, 1'b0, w, 1'b0);
        push(3'd4, 2'd0, rw,   1'b0, w, 1'b0);
        push(3'd1, 2'd1, 1'b0, 1'b0, w, 1'b0);
        for (int i = 0; i < n1; i++) push(3'd2, 2'd1, 1'b0, 1'b0, w, 1'b0);
        push(3'd3, 2'd1, 1'b0, 1'b0, w, 1'b0);
        push(3'd4, 2'd1, rw,   1'b0, w, 1'b0);
        push(3'd5, 2'd1, 1'b0, 1'b1, w, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, simd_state, 0);
        chk({tag, "_cwc"}, curr_wave_cycle, 0);
        chk({tag, "_wave_id"}, wave_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_reg_write"}, reg_write, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // Monitor: every busy cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_busy: got state %0d, expected idle (t=%0t)",
                         simd_state, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("state", simd_state, mon_e.st);
                chk("curr_wave_cycle", curr_wave_cycle, mon_e.cwc);
                chk("REG_WRITE", reg_write, mon_e.rw);
                chk("done", done, mon_e.dn);
                chk("wave_id", wave_id, mon_e.wid);
                chk("timeout_err", timeout_err, mon_e.te);
                chk("enable", enable, 1);
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        wave_id_in   = 0;
        reg_write_in = 1'b0;
        mem_op_in    = 1'b0;
        mem_ready    = 1'b0;

        tick(1);
        chk_reset_outputs("por");

        // Basic wave, start raised together with reset release.
        tick(1);
        rst_n        = 1'b1;
        wave_id_in   = 3;
        reg_write_in = 1'b1;
        start        = 1'b1;
        push_plain(3, 1'b1);
        tick(1);
        start = 1'b0;
        tick(7);
        chk("t1_idle", simd_state, 0);
        chk("t1_wave_id", wave_id, 3);
        chk("t1_queue", exp_q.size(), 0);

        // Memory op: mem_ready low for 4 WAIT edges, then high.
        wave_id_in   = 5;
        reg_write_in = 1'b0;
        mem_op_in    = 1'b1;
        start        = 1'b1;
        push_mem(5, 1'b0, 5, 1);
        tick(1);
        start = 1'b0;
        tick(5);
        mem_ready = 1'b1;
        tick(8);
        mem_ready = 1'b0;
        chk("t2_idle", simd_state, 0);
        chk("t2_queue", exp_q.size(), 0);

        // start pulses during EXECUTE and DONE must be ignored.
        wave_id_in   = 3;
        reg_write_in = 1'b1;
        mem_op_in    = 1'b0;
        start        = 1'b1;
        push_plain(3, 1'b1);
        tick(1);
        start = 1'b0;
        tick(1);
        start        = 1'b1;
        wave_id_in   = 9;
        reg_write_in = 1'b0;
        tick(1);
        start = 1'b0;
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t3_idle_after_done", simd_state, 0);
        chk("t3_wave_id_kept", wave_id, 3);
        chk("t3_queue", exp_q.size(), 0);

        // Reset in UPDATE of lane group 1.
        wave_id_in   = 7;
        reg_write_in = 1'b1;
        start        = 1'b1;
        push_plain(7, 1'b1);
        tick(1);
        start = 1'b0;
        tick(5);
        chk("t4_pre_state", simd_state, 4);
        chk("t4_pre_reg_write", reg_write, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t4_rst");
        exp_q.delete();
        tick(1);
        chk("t4_no_done", done, 0);
        chk("t4_still_idle", simd_state, 0);

        // Accept on the first edge after release; mem_ready held high gives 9 busy cycles.
        rst_n        = 1'b1;
        wave_id_in   = 11;
        reg_write_in = 1'b1;
        mem_op_in    = 1'b1;
        mem_ready    = 1'b1;
        start        = 1'b1;
        push_mem(11, 1'b1, 1, 1);
        tick(1);
        start = 1'b0;
        tick(9);
        mem_ready = 1'b0;
        chk("t5_idle", simd_state, 0);
        chk("t5_queue", exp_q.size(), 0);

`ifdef SIMD_WAIT_TIMEOUT_EN
        // Timeout after 4 WAIT cycles, sticky until next accept.
        wave_id_in   = 12;
        reg_write_in = 1'b0;
        mem_op_in    = 1'b1;
        start        = 1'b1;
        push(3'd1, 2'd0, 1'b0, 1'b0, 12, 1'b0);
        for (int i = 0; i < 4; i++) push(3'd2, 2'd0, 1'b0, 1'b0, 12, 1'b0);
        push(3'd5, 2'd0, 1'b0, 1'b1, 12, 1'b1);
        tick(1);
        start = 1'b0;
        tick(6);
        chk("t6_idle", simd_state, 0);
        chk("t6_err_sticky", timeout_err, 1);
        chk("t6_queue", exp_q.size(), 0);
        wave_id_in = 13;
        mem_op_in  = 1'b0;
        start      = 1'b1;
        push_plain(13, 1'b0);
        tick(1);
        start = 1'b0;
        tick(7);
        chk("t6_err_cleared", timeout_err, 0);
        chk("t6b_queue", exp_q.size(), 0);
`else
        // Without the timeout feature WAIT holds until mem_ready.
        wave_id_in   = 12;
        reg_write_in = 1'b0;
        mem_op_in    = 1'b1;
        start        = 1'b1;
        push_mem(12, 1'b0, 12, 1);
        tick(1);
        start = 1'b0;
        tick(12);
        chk("t6_still_wait", simd_state, 2);
        chk("t6_no_err", timeout_err, 0);
        mem_ready = 1'b1;
        tick(8);
        mem_ready = 1'b0;
        chk("t6_idle", simd_state, 0);
        chk("t6_queue", exp_q.size(), 0);
`endif

        tick(2);
        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
